// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the register file: two one-entry holding registers
// (pipeline writeback A with swap support, multi-cycle unit B) feeding a registered write port.
module regfile_wr_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int FAIR_RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_swap,
    input  logic [ADDR_W-1:0] a_reg1,
    input  logic [ADDR_W-1:0] a_reg2,
    input  logic [DATA_W-1:0] a_data1,
    input  logic [DATA_W-1:0] a_data2,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrt,
    output logic              RegSwp,
    output logic [ADDR_W-1:0] wrtRegOp1,
    output logic [ADDR_W-1:0] swpRegOp1,
    output logic [ADDR_W-1:0] swpRegOp2,
    output logic [DATA_W-1:0] wrtDataOp1,
    output logic [DATA_W-1:0] wrtDataOp2,
    output logic [1:0]        pending
);

    logic              haFull;
    logic              haSwap;
    logic [ADDR_W-1:0] haReg1;
    logic [ADDR_W-1:0] haReg2;
    logic [DATA_W-1:0] haData1;
    logic [DATA_W-1:0] haData2;

    logic              hbFull;
    logic [ADDR_W-1:0] hbReg;
    logic [DATA_W-1:0] hbData;

    logic lastGrantB;
    logic ageA;
    logic grantA;
    logic grantB;
    logic destConflict;
    logic aLoad;
    logic bLoad;

    // Grant looks only at holding state so ready never depends on valid.
    always_comb begin
        grantA       = 1'b0;
        grantB       = 1'b0;
        destConflict = (hbReg == haReg1) || (haSwap && (hbReg == haReg2));
        if (haFull && hbFull) begin
            if (destConflict) begin
                if (ageA) grantA = 1'b1;
                else      grantB = 1'b1;
            end else if ((FAIR_RR != 0) && !lastGrantB) begin
                grantB = 1'b1;
            end else begin
                grantA = 1'b1;
            end
        end else if (haFull) begin
            grantA = 1'b1;
        end else if (hbFull) begin
            grantB = 1'b1;
        end
    end

    assign a_ready = !haFull || grantA;
    assign b_ready = !hbFull || grantB;
    assign aLoad   = a_valid && a_ready;
    assign bLoad   = b_valid && b_ready;
    assign pending = {hbFull, haFull};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haFull  <= 1'b0;
            haSwap  <= 1'b0;
            haReg1  <= '0;
            haReg2  <= '0;
            haData1 <= '0;
            haData2 <= '0;
        end else if (aLoad) begin
            haFull  <= 1'b1;
            haSwap  <= a_swap;
            haReg1  <= a_reg1;
            haReg2  <= a_reg2;
            haData1 <= a_data1;
            haData2 <= a_data2;
        end else if (grantA) begin
            haFull <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hbFull <= 1'b0;
            hbReg  <= '0;
            hbData <= '0;
        end else if (bLoad) begin
            hbFull <= 1'b1;
            hbReg  <= b_reg;
            hbData <= b_data;
        end else if (grantB) begin
            hbFull <= 1'b0;
        end
    end

    // ageA=1 means HA holds the older entry; a lone load makes the other side older.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ageA       <= 1'b0;
            lastGrantB <= 1'b1;
        end else begin
            if (aLoad && bLoad) ageA <= 1'b1;
            else if (aLoad)     ageA <= 1'b0;
            else if (bLoad)     ageA <= 1'b1;

            if (grantA)      lastGrantB <= 1'b0;
            else if (grantB) lastGrantB <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrt     <= 1'b0;
            RegSwp     <= 1'b0;
            wrtRegOp1  <= '0;
            swpRegOp1  <= '0;
            swpRegOp2  <= '0;
            wrtDataOp1 <= '0;
            wrtDataOp2 <= '0;
        end else begin
            RegWrt     <= grantA || grantB;
            RegSwp     <= 1'b0;
            wrtRegOp1  <= '0;
            swpRegOp1  <= '0;
            swpRegOp2  <= '0;
            wrtDataOp1 <= '0;
            wrtDataOp2 <= '0;
            if (grantA) begin
                if (haSwap && (haReg1 != haReg2)) begin
                    RegSwp     <= 1'b1;
                    swpRegOp1  <= haReg1;
                    swpRegOp2  <= haReg2;
                    wrtDataOp1 <= haData1;
                    wrtDataOp2 <= haData2;
                end else if (haSwap) begin
                    // Swapping a register with itself degenerates to writing data2.
                    wrtRegOp1  <= haReg1;
                    wrtDataOp1 <= haData2;
                end else begin
                    wrtRegOp1  <= haReg1;
                    wrtDataOp1 <= haData1;
                end
            end else if (grantB) begin
                wrtRegOp1  <= hbReg;
                wrtDataOp1 <= hbData;
            end
        end
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - Requester A: in-order pipeline writeback; may issue normal writes or two-register swaps.
  - Requester B: multi-cycle unit writeback; normal writes only.
- Each requester has a one-entry holding register behind a valid/ready handshake.
- Grants one entry per cycle and drives the register file's RegWrt/RegSwp/address/data inputs from registered outputs.
- Sits between the writeback stage and the register file.

Parameters:
- ADDR_W, 4, register index width.
- DATA_W, 16, register data width.
- FAIR_RR, 1, 1 = round-robin between A and B; 0 = A always wins non-conflicting ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- a_valid  in  1  A presents a write.
- a_ready  out  1  A may transfer this cycle.
- a_swap  in  1  A request is a swap.
- a_reg1  in  ADDR_W  A destination (normal) / swap operand 1.
- a_reg2  in  ADDR_W  swap operand 2 (ignored if !a_swap).
- a_data1  in  DATA_W  normal write data / data destined for a_reg2 on swap.
- a_data2  in  DATA_W  data destined for a_reg1 on swap.
- b_valid  in  1  B presents a write.
- b_ready  out  1  B may transfer this cycle.
- b_reg  in  ADDR_W  B destination.
- b_data  in  DATA_W  B write data.
- RegWrt  out  1  register-file write enable.
- RegSwp  out  1  register-file swap select.
- wrtRegOp1  out  ADDR_W  normal write address.
- swpRegOp1  out  ADDR_W  swap address 1 (drives readOp1 during swap).
- swpRegOp2  out  ADDR_W  swap address 2 (drives readOp2 during swap).
- wrtDataOp1  out  DATA_W  data to wrtRegOp1, or to swpRegOp2 on swap.
- wrtDataOp2  out  DATA_W  data to swpRegOp1 on swap.
- pending  out  2  {HB full, HA full}.

Behaviour:
- Reset (rst low, asynchronous):
  - HA and HB empty; all outputs 0.
  - Last-grant pointer = B, so A wins the first round-robin tie.
  - Age bit cleared.
- Transfer: x_valid && x_ready at a rising edge loads Hx; data inputs must be stable only in that cycle.
- Readiness: x_ready = !Hx_full || grant_x (combinational from current holding state only, never from inputs). Back-to-back transfers at one per cycle per requester are therefore possible.
- Grant (combinational, evaluated on holding registers only):
  - Only one holding register full → that one is granted.
  - Both full and dest conflict → the older entry is granted. A dest conflict is b_reg equal to HA.reg1, or, for a swap, equal to HA.reg2.
  - Both full, no conflict → FAIR_RR=1 grants the side not granted last; FAIR_RR=0 grants A.
- Age bit: marks which holding register loaded first. When both load on the same edge, A is older.
- Output register: at the edge following grant:
  - RegWrt=1 and the address/data fields are loaded from the granted entry; that entry is cleared unless refilled on the same edge.
  - With no grant: RegWrt=0, RegSwp=0, and all address/data outputs = 0.
  - RegWrt is a one-cycle pulse per granted entry.
- Latency: accepted at edge N → outputs valid in cycle after N+1 → register file updates at edge N+2 (uncontended).
- Normal write: RegSwp=0, wrtRegOp1=reg, wrtDataOp1=data; swp fields 0.
- Swap (HA.swap, reg1≠reg2): RegSwp=1, swpRegOp1=reg1, swpRegOp2=reg2, wrtDataOp1=data1, wrtDataOp2=data2. Uses one port cycle.
- Degenerate swap (reg1==reg2): converted to a normal write, RegSwp=0, wrtRegOp1=reg1, wrtDataOp1=data2.
- Register 0 receives no special treatment; writes pass through.
- Reset mid-operation: held entries are discarded, and any in-flight RegWrt pulse drops immediately.

Test Plan:
- Single A write: a_valid 1 cycle, a_reg1=3, a_data1=16'h1234 → one cycle later RegWrt=1, wrtRegOp1=3, wrtDataOp1=16'h1234 for exactly one cycle; pending returns to 00.
- Simultaneous A(reg 5) and B(reg 7) after reset → A granted first, then B in the next cycle. Streaming both continuously alternates A,B,A,B; a_ready and b_ready each drop every other cycle.
- Conflict ordering: B(reg 4, 16'hAAAA) accepted one edge before A(reg 4, 16'hBBBB) → B written first, then A; final reg 4 = 16'hBBBB regardless of the round-robin pointer.
- Swap a_reg1=1, a_reg2=2, a_data1=16'h0F00, a_data2=16'h0050 → RegSwp=1, swpRegOp1=1, swpRegOp2=2, wrtDataOp1=16'h0F00, wrtDataOp2=16'h0050. Degenerate swap reg1=reg2=6 → RegSwp=0, wrtRegOp1=6, wrtDataOp1=a_data2.
- FAIR_RR=0 with A and B streaming non-conflicting writes → B granted only when HA empty; b_ready held low while A streams.
- Assert rst low with both holding registers full and RegWrt=1 → RegWrt and pending drop to 0 immediately; after release, no stale write occurs.
